// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready beat bus carrying a data bundle and a control bundle.
// Ports: valid, ready, data[DATA_W], ctrl[CTRL_W]; master drives the beat, slave drives ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with flush, ctrl bubble zeroing, stall counter.
// Ports: clk, rst (sync, active high), inBus (slave), outBus (master), ctrl_zero, flush,
// stall_cnt. Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int              DATA_W    = 64,
    parameter int              CTRL_W    = 16,
    parameter logic [CTRL_W-1:0] KILL_MASK = '0,
    parameter int              CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_reg_if.slave    inBus,
    pipe_stage_reg_if.master   outBus,
    input  logic               ctrl_zero,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic [CTRL_W-1:0] outCtrl;
    logic [CNT_W-1:0]  stallCnt;

    logic              inReady;
    logic              accept;
    logic              drain;
    logic              stalled;
    logic [CTRL_W-1:0] zeroMask;
    logic [CTRL_W-1:0] capCtrl;

    assign accept   = inBus.valid && inReady;
    assign drain    = outValid && outBus.ready;
    assign stalled  = outValid && !outBus.ready;
    assign zeroMask = ctrl_zero ? KILL_MASK : '0;
    assign capCtrl  = inBus.ctrl & ~zeroMask;

    assign inBus.ready  = inReady;
    assign outBus.valid = outValid;
    assign outBus.data  = outData;
    assign outBus.ctrl  = outCtrl;
    assign stall_cnt    = stallCnt;

`ifdef PIPE_SKID_EN
    logic              skidValid;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    // Ready depends only on state, breaking the out_ready -> in_ready path.
    assign inReady = !skidValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid  <= 1'b0;
            outData   <= '0;
            outCtrl   <= '0;
            skidValid <= 1'b0;
            skidData  <= '0;
            skidCtrl  <= '0;
        end else if (flush) begin
            outValid  <= 1'b0;
            outCtrl   <= outCtrl & ~KILL_MASK;
            skidValid <= 1'b0;
            skidCtrl  <= skidCtrl & ~KILL_MASK;
        end else if (accept && (!outValid || outBus.ready)) begin
            // Accept implies the skid slot is empty, so the beat goes straight to out.
            outValid <= 1'b1;
            outData  <= inBus.data;
            outCtrl  <= capCtrl;
        end else if (accept) begin
            skidValid <= 1'b1;
            skidData  <= inBus.data;
            skidCtrl  <= capCtrl;
        end else if (drain) begin
            if (skidValid) begin
                outData   <= skidData;
                outCtrl   <= skidCtrl;
                skidValid <= 1'b0;
            end else begin
                outValid <= 1'b0;
            end
        end
    end
`else
    assign inReady = !outValid || outBus.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            outData  <= '0;
            outCtrl  <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
            outCtrl  <= outCtrl & ~KILL_MASK;
        end else if (accept) begin
            outValid <= 1'b1;
            outData  <= inBus.data;
            outCtrl  <= capCtrl;
        end else if (drain) begin
            outValid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (stalled && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg.
// Works in both default and PIPE_SKID_EN builds.
module tb_pipe_stage_reg;

    localparam logic [15:0] KILL = 16'h0003;

    typedef struct {
        logic [63:0] data;
        logic [15:0] ctrl;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctrlZero;
    logic       flush;
    logic [7:0] stallCnt;
    logic [1:0] stallSat;

    int nCmp = 0;
    int nErr = 0;
    beat_t sb[$];

    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) inB ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) outB ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) inS ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) outS ();

    assign inS.valid  = inB.valid;
    assign inS.data   = inB.data;
    assign inS.ctrl   = inB.ctrl;
    assign outS.ready = outB.ready;

    pipe_stage_reg #(
        .DATA_W(64), .CTRL_W(16), .KILL_MASK(KILL), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .inBus(inB), .outBus(outB),
        .ctrl_zero(ctrlZero), .flush(flush), .stall_cnt(stallCnt)
    );

    pipe_stage_reg #(
        .DATA_W(64), .CTRL_W(16), .KILL_MASK(KILL), .CNT_W(2)
    ) dutSat (
        .clk(clk), .rst(rst), .inBus(inS), .outBus(outS),
        .ctrl_zero(ctrlZero), .flush(flush), .stall_cnt(stallSat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: score drains, then record accepts; flush wipes pending entries.
    task automatic step();
        beat_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            if (outB.valid && outB.ready) begin
                if (sb.size() == 0) begin
                    check("sb_spurious", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", outB.data, e.data);
                    check("sb_ctrl", {48'd0, outB.ctrl}, {48'd0, e.ctrl});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (inB.valid && inB.ready) begin
                e.data = inB.data;
                e.ctrl = inB.ctrl & ~(ctrlZero ? KILL : 16'h0000);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d,
                         input logic [15:0] c);
        inB.valid = v;
        inB.data  = d;
        inB.ctrl  = c;
    endtask

    initial begin
        rst        = 1'b1;
        ctrlZero   = 1'b0;
        flush      = 1'b0;
        outB.ready = 1'b1;
        drive(1'b1, 64'hA5, 16'h00FF);

        // Reset wins over a valid input beat.
        step();
        step();
        check("rst_valid", {63'd0, outB.valid}, 64'd0);
        check("rst_data", outB.data, 64'd0);
        check("rst_ctrl", {48'd0, outB.ctrl}, 64'd0);
        check("rst_cnt", {56'd0, stallCnt}, 64'd0);
        check("rst_cnt_sat", {62'd0, stallSat}, 64'd0);

        rst = 1'b0;
        step();
        check("cap_valid", {63'd0, outB.valid}, 64'd1);
        check("cap_data", outB.data, 64'hA5);
        check("cap_ctrl", {48'd0, outB.ctrl}, 64'h00FF);

        ctrlZero = 1'b1;
        drive(1'b1, 64'hB6, 16'h00FF);
        step();
        check("zero_valid", {63'd0, outB.valid}, 64'd1);
        check("zero_ctrl", {48'd0, outB.ctrl}, 64'h00FC);

        // Stall: hold B6 for five cycles.
        ctrlZero   = 1'b0;
        drive(1'b0, 64'h0, 16'h0);
        outB.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {63'd0, outB.valid}, 64'd1);
            check("stall_data", outB.data, 64'hB6);
            check("stall_ctrl", {48'd0, outB.ctrl}, 64'h00FC);
`ifdef PIPE_SKID_EN
            check("stall_rdy", {63'd0, inB.ready}, 64'd1);
`else
            check("stall_rdy", {63'd0, inB.ready}, 64'd0);
`endif
        end
        check("stall_cnt", {56'd0, stallCnt}, 64'd5);
        check("stall_sat", {62'd0, stallSat}, 64'd3);

        // Flush while stalled: entry dropped, incoming beat discarded.
        flush = 1'b1;
        drive(1'b1, 64'hC7, 16'h00FF);
        step();
        check("fl_valid", {63'd0, outB.valid}, 64'd0);
        check("fl_ctrl", {48'd0, outB.ctrl}, 64'h00FC);
        check("fl_data", outB.data, 64'hB6);
        check("fl_cnt", {56'd0, stallCnt}, 64'd6);
        flush = 1'b0;
        drive(1'b0, 64'h0, 16'h0);
        step();
        check("fl_gone", {63'd0, outB.valid}, 64'd0);
        check("fl_cnt_hold", {56'd0, stallCnt}, 64'd6);

        // Flush with drain: D8 taken downstream, E9 discarded.
        outB.ready = 1'b1;
        drive(1'b1, 64'hD8, 16'h0F0F);
        step();
        check("fd_data", outB.data, 64'hD8);
        flush = 1'b1;
        drive(1'b1, 64'hE9, 16'h00FF);
        #1;
        check("fd_rdy", {63'd0, inB.ready}, 64'd1);
        step();
        check("fd_valid", {63'd0, outB.valid}, 64'd0);
        check("fd_ctrl", {48'd0, outB.ctrl}, 64'h0F0C);
        flush = 1'b0;
        drive(1'b0, 64'h0, 16'h0);
        step();
        check("fd_gone", {63'd0, outB.valid}, 64'd0);

        // Back-to-back stream, one beat per cycle, latency 1.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h100 + 64'(i * 17), 16'(i + 1));
            step();
            check("b2b_valid", {63'd0, outB.valid}, 64'd1);
            check("b2b_data", outB.data, 64'h100 + 64'(i * 17));
        end
        drive(1'b0, 64'h0, 16'h0);
        step();
        check("b2b_end", {63'd0, outB.valid}, 64'd0);

`ifdef PIPE_SKID_EN
        outB.ready = 1'b0;
        drive(1'b1, 64'hB1, 16'h0011);
        step();
        check("sk_rdy1", {63'd0, inB.ready}, 64'd1);
        drive(1'b1, 64'hB2, 16'h0022);
        step();
        check("sk_rdy2", {63'd0, inB.ready}, 64'd0);
        check("sk_head", outB.data, 64'hB1);
        drive(1'b0, 64'h0, 16'h0);
        outB.ready = 1'b1;
        step();
        check("sk_b2_valid", {63'd0, outB.valid}, 64'd1);
        check("sk_b2_data", outB.data, 64'hB2);
        check("sk_rdy3", {63'd0, inB.ready}, 64'd1);
        step();
        check("sk_empty", {63'd0, outB.valid}, 64'd0);

        outB.ready = 1'b0;
        drive(1'b1, 64'hB3, 16'h0033);
        step();
        drive(1'b1, 64'hB4, 16'h0044);
        step();
        drive(1'b0, 64'h0, 16'h0);
        flush = 1'b1;
        step();
        flush      = 1'b0;
        outB.ready = 1'b1;
        check("sk_fl_valid", {63'd0, outB.valid}, 64'd0);
        check("sk_fl_rdy", {63'd0, inB.ready}, 64'd1);
        step();
        check("sk_fl_gone", {63'd0, outB.valid}, 64'd0);
`endif

        check("sb_left", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
